pos_manager_multi: RTL and testbench
====================================

Name: pos_manager_multi

Overview:
Parametrised successor of the two-motor position manager. It tracks NUM_CH hall/encoder sensor channels and keeps two counts per channel. The raw count is free-running. The relative count is renormalised against the channel minimum, so it never overflows while the inter-channel differences stay exact. It also exposes differences to channel 0, a snapshot of those differences, a clock-cycle counter and sticky saturation flags. It sits between the motor sensor pins and the speed/position control registers.

Parameters:
NUM_CH, 2, number of sensor channels (>=2)
POS_W, 16, width of each position count
CNT_W, 32, width of the clock-cycle counter
SYNC_STAGES, 2, synchroniser flops per sensor input (>=2)
EDGE_MODE, 0, 0 = count rising edges only; 1 = count both edges

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
sensor  in  NUM_CH  asynchronous sensor inputs, bit i = channel i
clear_cnt  in  1  level; zeroes count_clk
clear_pos  in  1  level; zeroes pos_raw, pos_rel and overflow
snap  in  1  level; its rising edge captures pos_diff
pos_raw  out  NUM_CH*POS_W  free-running edge count, channel i in bits [i*POS_W +: POS_W]
pos_rel  out  NUM_CH*POS_W  renormalised edge count, same packing
pos_diff  out  (NUM_CH-1)*POS_W  pos_rel[0]-pos_rel[i] for i=1..NUM_CH-1, slot i-1, combinational
pos_diff_snap  out  (NUM_CH-1)*POS_W  registered copy of pos_diff
snap_valid  out  1  one-cycle pulse, the cycle after a capture
count_clk  out  CNT_W  clock-cycle counter
overflow  out  NUM_CH  sticky per channel: a pos_rel increment was dropped at saturation

Behaviour:
- Reset: on a clk edge with reset=1, clear everything: synchronisers, edge-history regs, snap_prev, pos_raw, pos_rel, pos_diff_snap, snap_valid, count_clk, overflow. Reset overrides all other inputs.
- Sync: each sensor bit passes through SYNC_STAGES flops to give s_i. prev_i is s_i delayed one cycle.
- Edge detect: edge_i = s_i & ~prev_i when EDGE_MODE=0; edge_i = s_i ^ prev_i when EDGE_MODE=1.
- Latency: a sensor transition set up before clk edge 0 appears on the counts after edge SYNC_STAGES (SYNC_STAGES+1 rising edges in total).
- pos_raw_i: clear_pos -> 0. Otherwise, on edge_i, +1 modulo 2^POS_W (silent wrap, no flag).
- Renormalisation: renorm = OR over i of pos_rel_i[POS_W-1]. min_rel = unsigned minimum of all pos_rel_i, combinational.
- pos_rel_i priority, highest first:
  1. clear_pos -> 0.
  2. renorm -> pos_rel_i - min_rel + edge_i.
  3. edge_i -> pos_rel_i + 1.
  4. otherwise hold.
- Saturation: when pos_rel_i = 2^POS_W-1 and the increment is not absorbed by renorm, hold all-ones and set overflow_i. The check uses the post-subtract value.
- overflow_i: cleared only by reset or clear_pos. Once set, pos_diff for that channel is invalid until cleared.
- Differences: pos_diff slot i-1 = pos_rel_0 - pos_rel_i, POS_W bits, two's complement, wraps. Renorm leaves differences unchanged except for same-cycle edges.
- Snapshot: snap_prev <= snap. When snap & ~snap_prev, pos_diff_snap <= pos_diff (pre-update values of that cycle) and snap_valid goes high the next cycle for exactly one cycle. A held-high snap captures once.
- count_clk: clear_cnt -> 0, else +1 with wrap. Independent of clear_pos.
- Simultaneous events:
  - clear_pos together with an edge: the clear wins and the edge is lost.
  - snap together with clear_pos: captures the pre-clear differences.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with the sensors toggling -> all outputs 0. Release reset, no sensor activity -> count_clk = 1, 2, 3 on successive edges.
2. Latency/count (EDGE_MODE=0, SYNC_STAGES=2): 3 rising pulses on sensor[0] -> pos_raw0 = pos_rel0 = 3, pos_diff = 3. The first increment is visible after the 3rd clk edge following the first rise.
3. Both-edge (EDGE_MODE=1): 4 rising and 4 falling transitions on sensor[1] -> pos_raw1 = 8, pos_diff slot0 = 0xFFF8 (-8).
4. Renormalisation (POS_W=8): drive ch0 to 127 and ch1 to 100, then one more ch0 edge -> pos_rel0 = 128, next cycle pos_rel0 = 28, pos_rel1 = 0. pos_raw unchanged, pos_diff = 28 throughout.
5. Saturation (POS_W=8): ch1 idle, 300 edges on ch0 -> pos_rel0 = 255, overflow = 2'b01, pos_raw0 = 44. Then clear_pos -> all 0, overflow = 0.
6. Snapshot: pos_diff = 5, snap held high for 3 cycles -> pos_diff_snap = 5 and a single snap_valid pulse. Add further edges -> pos_diff_snap stays 5 until the next snap rise.

Source files
------------

// File: rtl/pos_manager_multi.sv
// Multi-channel sensor position manager: synchronises NUM_CH sensor inputs,
// counts their edges into a free-running raw count and a renormalised
// relative count, and exposes differences to channel 0, a snapshot of those
// differences, a clock-cycle counter and sticky saturation flags.
//
// Handshake: snap_valid is a one-cycle pulse with no ready. It is raised the
// cycle after a snap rising edge captures pos_diff. pos_diff_snap then holds
// that value until the next capture, so a consumer may read it at any time.
module pos_manager_multi #(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = 16,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           sensor,
  input  logic                        clear_cnt,
  input  logic                        clear_pos,
  input  logic                        snap,
  output logic [NUM_CH*POS_W-1:0]     pos_raw,
  output logic [NUM_CH*POS_W-1:0]     pos_rel,
  output logic [(NUM_CH-1)*POS_W-1:0] pos_diff,
  output logic [(NUM_CH-1)*POS_W-1:0] pos_diff_snap,
  output logic                        snap_valid,
  output logic [CNT_W-1:0]            count_clk,
  output logic [NUM_CH-1:0]           overflow
);

  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s_sync;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] edge_v;

  logic [POS_W-1:0]  raw_q [NUM_CH];
  logic [POS_W-1:0]  rel_q [NUM_CH];
  logic [POS_W-1:0]  raw_d [NUM_CH];
  logic [POS_W-1:0]  rel_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_d;
  logic [POS_W-1:0]  base;

  logic              renorm;
  logic [POS_W-1:0]  min_rel;
  logic              snap_prev;
  logic              snap_rise;

  // Synchroniser chain plus one-cycle edge history per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sensor;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s_sync;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign edge_v = (EDGE_MODE != 0) ? (s_sync ^ prev_q) : (s_sync & ~prev_q);

  // Renormalise whenever any relative count reaches its top half
  always_comb begin
    renorm  = 1'b0;
    min_rel = rel_q[0];
    for (int i = 0; i < NUM_CH; i++) begin
      renorm = renorm | rel_q[i][POS_W-1];
      if (rel_q[i] < min_rel) min_rel = rel_q[i];
    end
  end

  // Next counts: clear wins, then renorm-with-edge, then plain increment
  always_comb begin
    base  = '0;
    ovf_d = overflow;
    for (int i = 0; i < NUM_CH; i++) begin
      raw_d[i] = raw_q[i];
      rel_d[i] = rel_q[i];
      if (clear_pos) begin
        raw_d[i] = '0;
        rel_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        if (edge_v[i]) raw_d[i] = raw_q[i] + 1'b1;
        // Saturation is judged on the value after the renorm subtract
        base = renorm ? (rel_q[i] - min_rel) : rel_q[i];
        if (edge_v[i]) begin
          if (base == POS_MAX) begin
            rel_d[i] = base;
            ovf_d[i] = 1'b1;
          end else begin
            rel_d[i] = base + 1'b1;
          end
        end else begin
          rel_d[i] = base;
        end
      end
    end
  end

  // Count and overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        raw_q[i] <= '0;
        rel_q[i] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        raw_q[i] <= raw_d[i];
        rel_q[i] <= rel_d[i];
      end
      overflow <= ovf_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_pack
      assign pos_raw[g*POS_W +: POS_W] = raw_q[g];
      assign pos_rel[g*POS_W +: POS_W] = rel_q[g];
    end
    for (g = 1; g < NUM_CH; g++) begin : g_diff
      assign pos_diff[(g-1)*POS_W +: POS_W] = rel_q[0] - rel_q[g];
    end
  endgenerate

  assign snap_rise = snap & ~snap_prev;

  // Capture differences on a snap rising edge, pulse snap_valid after
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_prev     <= 1'b0;
      pos_diff_snap <= '0;
      snap_valid    <= 1'b0;
    end else begin
      snap_prev  <= snap;
      snap_valid <= snap_rise;
      if (snap_rise) pos_diff_snap <= pos_diff;
    end
  end

  // Free-running clock-cycle counter with its own clear
  always_ff @(posedge clk) begin
    if (reset || clear_cnt) count_clk <= '0;
    else                    count_clk <= count_clk + 1'b1;
  end

endmodule

// File: tb/tb_pos_manager_multi.sv
// Bench for pos_manager_multi: two instances (rising-edge and both-edge
// counting) share one stimulus stream and are checked against an
// event-level reference model of the edge counts.
`timescale 1ns/1ps
module tb_pos_manager_multi;

  localparam int NUM_CH = 2;
  localparam int POS_W  = 8;
  localparam int CNT_W  = 8;
  localparam int SS     = 2;
  localparam int DW     = (NUM_CH-1)*POS_W;
  localparam int PMOD   = 1 << POS_W;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear_cnt, clear_pos, snap;
  logic [NUM_CH-1:0] sensor;

  logic [NUM_CH*POS_W-1:0] raw_r, rel_r, raw_b, rel_b;
  logic [DW-1:0]           diff_r, dsnap_r, diff_b, dsnap_b;
  logic                    sv_r, sv_b;
  logic [CNT_W-1:0]        cnt_r, cnt_b;
  logic [NUM_CH-1:0]       ovf_r, ovf_b;

  pos_manager_multi #(.NUM_CH(NUM_CH), .POS_W(POS_W), .CNT_W(CNT_W),
                      .SYNC_STAGES(SS), .EDGE_MODE(0)) dut_r (
    .clk(clk), .reset(reset), .sensor(sensor), .clear_cnt(clear_cnt),
    .clear_pos(clear_pos), .snap(snap), .pos_raw(raw_r), .pos_rel(rel_r),
    .pos_diff(diff_r), .pos_diff_snap(dsnap_r), .snap_valid(sv_r),
    .count_clk(cnt_r), .overflow(ovf_r));

  pos_manager_multi #(.NUM_CH(NUM_CH), .POS_W(POS_W), .CNT_W(CNT_W),
                      .SYNC_STAGES(SS), .EDGE_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .sensor(sensor), .clear_cnt(clear_cnt),
    .clear_pos(clear_pos), .snap(snap), .pos_raw(raw_b), .pos_rel(rel_b),
    .pos_diff(diff_b), .pos_diff_snap(dsnap_b), .snap_valid(sv_b),
    .count_clk(cnt_b), .overflow(ovf_b));

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [2*DW-1:0] exp_q[$];   // {both-edge diff, rising-edge diff}
  logic [2*DW-1:0] exp_e;

  // Reference model: index 0 = rising-edge instance, 1 = both-edge instance
  int m_raw [2][NUM_CH];
  int m_rel [2][NUM_CH];
  bit m_ovf [2][NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NUM_CH; c++) begin
        m_raw[m][c] = 0;
        m_rel[m][c] = 0;
        m_ovf[m][c] = 1'b0;
      end
  endfunction

  // One counted event on the channels in hit, then pull counts down by the
  // smallest one whenever any count has reached the top half of its range.
  function automatic void model_event(input int m, input logic [NUM_CH-1:0] hit);
    int mn;
    bit big;
    for (int c = 0; c < NUM_CH; c++)
      if (hit[c]) begin
        m_raw[m][c] = (m_raw[m][c] + 1) % PMOD;
        if (m_rel[m][c] == PMOD - 1) m_ovf[m][c] = 1'b1;
        else                         m_rel[m][c] = m_rel[m][c] + 1;
      end
    big = 1'b0;
    mn  = m_rel[m][0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_rel[m][c] >= PMOD / 2) big = 1'b1;
      if (m_rel[m][c] < mn) mn = m_rel[m][c];
    end
    if (big)
      for (int c = 0; c < NUM_CH; c++) m_rel[m][c] = m_rel[m][c] - mn;
  endfunction

  function automatic logic [NUM_CH*POS_W-1:0] model_vec(input int m, input bit rel);
    logic [NUM_CH*POS_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++)
      v[c*POS_W +: POS_W] = rel ? POS_W'(m_rel[m][c]) : POS_W'(m_raw[m][c]);
    return v;
  endfunction

  function automatic logic [DW-1:0] model_diff(input int m);
    logic [DW-1:0] d;
    d = '0;
    for (int c = 1; c < NUM_CH; c++)
      d[(c-1)*POS_W +: POS_W] = POS_W'(m_rel[m][0] - m_rel[m][c]);
    return d;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ovf(input int m);
    logic [NUM_CH-1:0] o;
    for (int c = 0; c < NUM_CH; c++) o[c] = m_ovf[m][c];
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sensor(input logic [NUM_CH-1:0] nv, input int hold);
    logic [NUM_CH-1:0] tg, rs;
    @(posedge clk); #1;
    tg = nv ^ sensor;
    rs = nv & ~sensor;
    sensor = nv;
    model_event(0, rs);
    model_event(1, tg);
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic pulses(input logic [NUM_CH-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      drive_sensor(mask, 2);
      drive_sensor('0, 2);
    end
  endtask

  task automatic settle();
    repeat (SS + 3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear_pos = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clear_pos = 1'b0;
  endtask

  task automatic do_snap(input int hi, input bit with_clear);
    @(posedge clk); #1;
    snap      = 1'b1;
    clear_pos = with_clear;
    exp_q.push_back({model_diff(1), model_diff(0)});
    if (with_clear) model_clear();
    @(posedge clk); #1;
    clear_pos = 1'b0;
    repeat (hi - 1) @(posedge clk);
    #1 snap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk($sformatf("%s raw_r", tag),  32'(raw_r),  32'(model_vec(0, 0)));
    chk($sformatf("%s rel_r", tag),  32'(rel_r),  32'(model_vec(0, 1)));
    chk($sformatf("%s diff_r", tag), 32'(diff_r), 32'(model_diff(0)));
    chk($sformatf("%s ovf_r", tag),  32'(ovf_r),  32'(model_ovf(0)));
    chk($sformatf("%s raw_b", tag),  32'(raw_b),  32'(model_vec(1, 0)));
    chk($sformatf("%s rel_b", tag),  32'(rel_b),  32'(model_vec(1, 1)));
    chk($sformatf("%s diff_b", tag), 32'(diff_b), 32'(model_diff(1)));
    chk($sformatf("%s ovf_b", tag),  32'(ovf_b),  32'(model_ovf(1)));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sv_r || sv_b) begin
      chk("snap_valid_pair", {30'b0, sv_b, sv_r}, 32'd3);
      if (exp_q.size() == 0) begin
        chk("snap_unexpected_pulse", {30'b0, sv_b, sv_r}, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("snap_diff_r", 32'(dsnap_r), 32'(exp_e[DW-1:0]));
        chk("snap_diff_b", 32'(dsnap_b), 32'(exp_e[2*DW-1:DW]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clear_cnt = 1'b0; clear_pos = 1'b0; snap = 1'b0;
    sensor = '0;
    model_clear();

    // 1. reset with sensors toggling, then the cycle counter starts at 1
    repeat (2) begin
      @(posedge clk); #1;
      sensor = ~sensor;
    end
    chk("rst raw_r", 32'(raw_r), 0);   chk("rst rel_r", 32'(rel_r), 0);
    chk("rst diff_r", 32'(diff_r), 0); chk("rst dsnap_r", 32'(dsnap_r), 0);
    chk("rst sv_r", 32'(sv_r), 0);     chk("rst cnt_r", 32'(cnt_r), 0);
    chk("rst ovf_r", 32'(ovf_r), 0);   chk("rst raw_b", 32'(raw_b), 0);
    chk("rst dsnap_b", 32'(dsnap_b), 0); chk("rst cnt_b", 32'(cnt_b), 0);
    sensor = '0;
    reset  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cnt_after_reset_%0d", k), 32'(cnt_r), 32'(k));
      chk($sformatf("cnt_b_after_reset_%0d", k), 32'(cnt_b), 32'(k));
    end
    check_state("post_reset");

    // 2. latency: first increment visible after the third edge
    @(posedge clk); #1;
    sensor[0] = 1'b1;
    model_event(0, 2'b01);
    model_event(1, 2'b01);
    @(posedge clk); #1; chk("lat edge0 raw_r", 32'(raw_r[7:0]), 0);
    @(posedge clk); #1; chk("lat edge1 raw_r", 32'(raw_r[7:0]), 0);
    chk("lat edge1 raw_b", 32'(raw_b[7:0]), 0);
    @(posedge clk); #1; chk("lat edge2 raw_r", 32'(raw_r[7:0]), 1);
    chk("lat edge2 raw_b", 32'(raw_b[7:0]), 1);
    drive_sensor('0, 2);
    pulses(2'b01, 2);
    settle();
    chk("cnt3 raw_r0", 32'(raw_r[7:0]), 3);
    chk("cnt3 rel_r0", 32'(rel_r[7:0]), 3);
    chk("cnt3 diff_r", 32'(diff_r), 3);
    check_state("count3");
    do_snap(3, 1'b0);

    // 3. both-edge counting on channel 1
    do_clear();
    pulses(2'b10, 4);
    settle();
    chk("both raw_b1", 32'(raw_b[15:8]), 8);
    chk("both diff_b", 32'(diff_b), 32'h0F8);
    chk("both raw_r1", 32'(raw_r[15:8]), 4);
    check_state("both_edge");

    // clear_pos landing on the same cycle as an edge: the edge is lost
    @(posedge clk); #1;
    sensor[0] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    clear_pos = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clear_pos = 1'b0;
    settle();
    check_state("clear_with_edge");
    drive_sensor('0, 2);
    settle();
    check_state("fall_after_clear");

    // 4. renormalisation
    do_clear();
    pulses(2'b11, 100);
    pulses(2'b01, 27);
    settle();
    chk("pre_renorm rel_r", 32'(rel_r), 32'h647F);
    @(posedge clk); #1;
    sensor = 2'b01;
    model_event(0, 2'b01);
    model_event(1, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("renorm top rel_r", 32'(rel_r), 32'h6480);
    chk("renorm top diff_r", 32'(diff_r), 28);
    @(posedge clk); #1;
    chk("renorm done rel_r", 32'(rel_r), 32'h001C);
    chk("renorm done raw_r", 32'(raw_r), 32'h6480);
    chk("renorm done diff_r", 32'(diff_r), 28);
    drive_sensor('0, 2);
    settle();
    check_state("renorm");

    // 5. saturation, then clear_pos
    do_clear();
    pulses(2'b01, 300);
    settle();
    chk("sat rel_r0", 32'(rel_r[7:0]), 255);
    chk("sat ovf_r", 32'(ovf_r), 1);
    chk("sat raw_r0", 32'(raw_r[7:0]), 44);
    check_state("saturate");
    do_clear();
    settle();
    chk("sat_clear rel_r", 32'(rel_r), 0);
    chk("sat_clear ovf_r", 32'(ovf_r), 0);
    check_state("sat_clear");

    // 6. snapshot held high captures once, and stays until the next rise
    pulses(2'b01, 5);
    settle();
    do_snap(3, 1'b0);
    chk("snap held dsnap_r", 32'(dsnap_r), 5);
    pulses(2'b01, 2);
    settle();
    chk("snap stays dsnap_r", 32'(dsnap_r), 5);
    check_state("snap_more");
    do_snap(1, 1'b1);
    settle();
    check_state("snap_with_clear");

    // 7. randomized traffic
    for (int it = 0; it < 80; it++) begin
      drive_sensor(2'($urandom_range(0, 3)), $urandom_range(2, 4));
      if (it % 10 == 9) begin
        settle();
        check_state($sformatf("rand_%0d", it));
        do_snap($urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      end
    end

    // 8. clock counter clear and wrap
    @(posedge clk); #1;
    clear_cnt = 1'b1;
    @(posedge clk); #1;
    chk("cnt cleared", 32'(cnt_r), 0);
    clear_cnt = 1'b0;
    repeat (260) @(posedge clk);
    #1;
    chk("cnt wrap r", 32'(cnt_r), 4);
    chk("cnt wrap b", 32'(cnt_b), 4);

    settle();
    chk("snap queue drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
